ext_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate extender. Each beat carries an immediate or a loaded data word, which the block extends to `DATA_W` bits in one of eight modes. The block covers immediate extension (zero, sign, upper, branch-offset) and sub-word load extension (byte/halfword, signed/unsigned, with byte-offset lane select and misalignment flag). Results are registered behind a 2-entry valid/ready skid buffer with a synchronous flush, so the block sits between pipeline stages (ID→EX for immediates, MEM→WB for loads) with full throughput and no combinational ready path.

---
 rtl/ext_pipe.sv | 89 ++++++++
 tb/tb_ext_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate/load extender behind a 2-entry valid/ready skid buffer
module ext_pipe #(
  parameter int IMM_W = 16,
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        EOp,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext,
  output logic              out_err
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t count, count_n;
  logic [DATA_W-1:0] sext, res, skid;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [OFF_W-1:0] hoff;
  logic err, skid_err, push, pop, ld_out, ld_skid, from_skid;
  always_comb begin
    hoff = in_off & ~OFF_W'(1);
    byte_v = 8'(in_word >> {in_off, 3'b000});
    half_v = 16'(in_word >> {hoff, 3'b000});
    sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    res = EOp == 3'd0 ? {{(DATA_W-IMM_W){1'b0}}, imm} :
          EOp == 3'd1 ? sext :
          EOp == 3'd2 ? {imm, {(DATA_W-IMM_W){1'b0}}} :
          EOp == 3'd3 ? sext << 2 :
          EOp == 3'd4 ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
          EOp == 3'd5 ? {{(DATA_W-8){1'b0}}, byte_v} :
          EOp == 3'd6 ? {{(DATA_W-16){half_v[15]}}, half_v} :
                        {{(DATA_W-16){1'b0}}, half_v};
    err = EOp[2] & EOp[1] & in_off[0];
  end
  assign in_ready = count != FULL;
  assign out_valid = count != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    count_n = count;
    ld_out = 1'b0;
    ld_skid = 1'b0;
    from_skid = 1'b0;
    case (count)
      EMPTY: if (push) begin
        count_n = ONE;
        ld_out = 1'b1;
      end
      ONE: if (push && pop) ld_out = 1'b1;
        else if (push) begin
          count_n = FULL;
          ld_skid = 1'b1;
        end else if (pop) count_n = EMPTY;
      FULL: if (pop) begin
        count_n = ONE;
        from_skid = 1'b1;
      end
      default: count_n = EMPTY;
    endcase
    if (flush) begin
      count_n = EMPTY;
      ld_out = 1'b0;
      ld_skid = 1'b0;
      from_skid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= EMPTY;
      ext <= '0;
      out_err <= 1'b0;
      skid <= '0;
      skid_err <= 1'b0;
    end else begin
      count <= count_n;
      if (ld_out) {ext, out_err} <= {res, err};
      else if (from_skid) {ext, out_err} <= {skid, skid_err};
      if (ld_skid) {skid, skid_err} <= {res, err};
    end
  end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe
module tb_ext_pipe;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, ordy = 0, rnd = 0, rmode = 0;
  logic in_ready, out_valid, out_err, out_ready;
  logic [2:0] EOp = 0;
  logic [15:0] imm = 0;
  logic [31:0] in_word = 0, ext;
  logic [1:0] in_off = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_beat;
  int errors = 0, checks = 0, cyc = 0, pops = 0, first_pop = -1, last_pop = -1, stalls = 0;

  assign out_ready = rmode ? rnd : ordy;

  ext_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .EOp(EOp), .imm(imm), .in_word(in_word), .in_off(in_off), .out_valid(out_valid),
    .out_ready(out_ready), .ext(ext), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [32:0] model(logic [2:0] op, logic [15:0] i, logic [31:0] w, logic [1:0] o);
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] s, r;
    b = w[8*o +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    s = {{16{i[15]}}, i};
    case (op)
      3'd0: r = {16'h0, i};
      3'd1: r = s;
      3'd2: r = {i, 16'h0};
      3'd3: r = s * 4;
      3'd4: r = {{24{b[7]}}, b};
      3'd5: r = {24'h0, b};
      3'd6: r = {{16{h[15]}}, h};
      default: r = {16'h0, h};
    endcase
    return {r, op[2] & op[1] & o[0]};
  endfunction

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      chk("beat expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_beat = sb.pop_front();
        chk("beat", {ext, out_err}, exp_beat);
      end
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] i, input logic [31:0] w,
                      input logic [1:0] o, input logic [32:0] want);
    int n = 0;
    in_valid = 1; EOp = op; imm = i; in_word = w; in_off = o;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    stalls += n;
    chk("accept timeout", 64'(n < 20), 1);
    sb.push_back(want);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic sendm(input logic [2:0] op, input logic [15:0] i, input logic [31:0] w, input logic [1:0] o);
    send(op, i, w, o, model(op, i, w, o));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  task automatic clr_pops();
    pops = 0; first_pop = -1; last_pop = -1;
  endtask

  localparam logic [32:0] A = {32'h00001111, 1'b0};
  localparam logic [32:0] B = {32'hFFFF8002, 1'b0};
  localparam logic [32:0] C = {32'h00001234, 1'b1};
  localparam logic [32:0] D = {32'h000000C7, 1'b0};

  initial begin
    logic [31:0] imm_exp [4] = '{32'h0000FFFD, 32'hFFFFFFFD, 32'hFFFD0000, 32'hFFFFFFF4};
    logic [2:0] ld_op [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    logic [1:0] ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1};
    logic [32:0] ld_exp [5] = '{{32'hFFFFFF80, 1'b0}, {32'h00000080, 1'b0}, {32'hFFFF80FF, 1'b0},
                                {32'h000080FF, 1'b0}, {32'h00007F01, 1'b1}};
    @(posedge clk); #1;
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst in_ready", 64'(in_ready), 1);
    chk("rst ext", 64'(ext), 0);
    chk("rst out_err", 64'(out_err), 0);
    reset = 0;
    ordy = 1;
    for (int k = 0; k < 4; k++) begin
      send(3'(k), 16'hFFFD, 32'h0, 2'd0, {imm_exp[k], 1'b0});
      chk("imm latency", 64'(out_valid), 1);
    end
    for (int k = 0; k < 5; k++) send(ld_op[k], 16'hABCD, 32'h80FF7F01, ld_off[k], ld_exp[k]);
    drain();
    ordy = 0;
    clr_pops();
    send(3'd0, 16'h1111, 32'h0, 2'd0, A);
    send(3'd1, 16'h8002, 32'h0, 2'd0, B);
    chk("bp in_ready low", 64'(in_ready), 0);
    in_valid = 1; EOp = 3'd7; in_word = 32'h12345678; in_off = 2'd3;
    repeat (2) begin @(posedge clk); #1; end
    chk("bp hold in_ready", 64'(in_ready), 0);
    chk("bp hold A", {ext, out_err}, A);
    ordy = 1;
    send(3'd7, 16'h0, 32'h12345678, 2'd3, C);
    drain();
    chk("bp pops", 64'(pops), 3);
    chk("bp consecutive", 64'(last_pop - first_pop), 2);
    clr_pops();
    stalls = 0;
    for (int k = 0; k < 16; k++)
      sendm(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 2'($urandom_range(0, 3)));
    chk("stream stalls", 64'(stalls), 0);
    drain();
    chk("stream pops", 64'(pops), 16);
    chk("stream consecutive", 64'(last_pop - first_pop), 15);
    rmode = 1;
    for (int k = 0; k < 30; k++)
      sendm(3'($urandom_range(0, 7)), 16'($urandom), $urandom, 2'($urandom_range(0, 3)));
    drain();
    rmode = 0;
    ordy = 0;
    send(3'd0, 16'h1111, 32'h0, 2'd0, A);
    send(3'd1, 16'h8002, 32'h0, 2'd0, B);
    flush = 1; in_valid = 1; EOp = 3'd7; in_word = 32'h12345678; in_off = 2'd3;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    chk("flush full out_valid", 64'(out_valid), 0);
    chk("flush full in_ready", 64'(in_ready), 1);
    clr_pops();
    ordy = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("flush full no beats", 64'(pops), 0);
    send(3'd5, 16'h0, 32'hA5B6C7D8, 2'd1, D);
    drain();
    chk("flush then D", 64'(pops), 1);
    ordy = 0;
    send(3'd0, 16'h1111, 32'h0, 2'd0, A);
    flush = 1; in_valid = 1; EOp = 3'd1; imm = 16'h8002;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    chk("flush push out_valid", 64'(out_valid), 0);
    clr_pops();
    ordy = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("flush push no beats", 64'(pops), 0);
    ordy = 0;
    send(3'd7, 16'h0, 32'h12345678, 2'd3, C);
    reset = 1; in_valid = 1; EOp = 3'd5; in_word = 32'hA5B6C7D8; in_off = 2'd1;
    @(posedge clk); #1;
    reset = 0; in_valid = 0;
    sb.delete();
    chk("mid rst out_valid", 64'(out_valid), 0);
    chk("mid rst in_ready", 64'(in_ready), 1);
    chk("mid rst ext", 64'(ext), 0);
    chk("mid rst out_err", 64'(out_err), 0);
    clr_pops();
    ordy = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid rst no beats", 64'(pops), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
